// File: rtl/mmix_defs.sv
// mmix_defs: shared owner encoding and access-size constants for the core memory port
package mmix_defs;
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_t;
  localparam logic [1:0] DS_BYTE  = 2'd0;
  localparam logic [1:0] DS_WYDE  = 2'd1;
  localparam logic [1:0] DS_TETRA = 2'd2;
  localparam logic [1:0] DS_OCTA  = 2'd3;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory port between fetch and load/store, with starvation guard and CSWAP lock
module mem_port_arbiter
  import mmix_defs::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] f_address,
  input  logic        f_read,
  output logic [63:0] f_readdata,
  output logic        f_done,
  input  logic [63:0] d_address,
  input  logic [1:0]  d_datasize,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [63:0] d_writedata,
  input  logic        d_lock,
  output logic [63:0] d_readdata,
  output logic        d_done,
  output logic [63:0] m_address,
  output logic [1:0]  m_datasize,
  output logic        m_read,
  output logic        m_write,
  output logic [63:0] m_writedata,
  input  logic [63:0] m_readdata,
  input  logic        m_done,
  output logic [1:0]  owner
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  logic [1:0] state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       d_req, is_fetch, is_data, data_win;
  assign d_req    = d_read | d_write;
  assign is_fetch = state == S_FETCH;
  assign is_data  = state[1];
  // Data may jump the queue only while fetch has not yet been passed over LIMIT times
  assign data_win = d_req & ((cnt < LIMIT) | ~f_read);
  assign owner       = is_data ? DATA : is_fetch ? FETCH : NONE;
  assign m_address   = is_data ? d_address : is_fetch ? f_address : '0;
  assign m_datasize  = is_data ? d_datasize : is_fetch ? DS_TETRA : DS_BYTE;
  assign m_read      = is_data ? d_read : is_fetch & f_read;
  assign m_write     = is_data & d_write & ~d_read;
  assign m_writedata = is_data ? d_writedata : '0;
  assign f_done      = m_done & is_fetch;
  assign d_done      = m_done & is_data;
  assign f_readdata  = m_readdata;
  assign d_readdata  = m_readdata;
  // Arbitration in IDLE, completion/abort/lock handling while owned
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        state_n = data_win ? S_DATA : f_read ? S_FETCH : S_IDLE;
        cnt_n   = (f_read & data_win) ? cnt + 4'd1 : 4'd0;
      end
      S_FETCH:  state_n = (m_done | ~f_read) ? S_IDLE : S_FETCH;
      S_DATA:   state_n = m_done ? (d_lock ? S_LOCKED : S_IDLE) : d_req ? S_DATA : S_IDLE;
      default:  state_n = m_done ? (d_lock ? S_LOCKED : S_IDLE) : (d_lock | d_req) ? S_LOCKED : S_IDLE;
    endcase
  end
  // State and starve counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors against hand-computed arbiter behaviour
module tb_mem_port_arbiter;
  logic        clk = 0;
  logic        reset;
  logic [63:0] f_address, f_readdata, d_address, d_writedata, d_readdata;
  logic [63:0] m_address, m_writedata, m_readdata;
  logic        f_read, f_done, d_read, d_write, d_lock, d_done;
  logic [1:0]  d_datasize, m_datasize, owner;
  logic        m_read, m_write, m_done;
  int          n_chk = 0, n_ok = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .f_address(f_address), .f_read(f_read), .f_readdata(f_readdata), .f_done(f_done),
    .d_address(d_address), .d_datasize(d_datasize), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_lock(d_lock), .d_readdata(d_readdata), .d_done(d_done),
    .m_address(m_address), .m_datasize(m_datasize), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_done(m_done), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; f_address = 0; f_read = 0; d_address = 0; d_datasize = 0;
    d_read = 0; d_write = 0; d_writedata = 0; d_lock = 0; m_readdata = 0; m_done = 0;
    nxt; f_read = 1; f_address = 64'h100;
    #1;
    chk("rst_owner", 64'(owner), 0);
    chk("rst_mread", 64'(m_read), 0);
    chk("rst_maddr", m_address, 0);
    chk("rst_mds", 64'(m_datasize), 0);
    nxt; reset = 0;
    #1 chk("f_idle_owner", 64'(owner), 0);
    nxt; #1;
    chk("f_owner", 64'(owner), 1);
    chk("f_mread", 64'(m_read), 1);
    chk("f_maddr", m_address, 64'h100);
    chk("f_mds", 64'(m_datasize), 2);
    nxt;
    nxt; m_done = 1; m_readdata = 64'hDEAD;
    #1;
    chk("f_done", 64'(f_done), 1);
    chk("f_rdata", f_readdata, 64'hDEAD);
    chk("f_ddone", 64'(d_done), 0);
    nxt; m_done = 0; f_read = 0;
    #1;
    chk("f_after_owner", 64'(owner), 0);
    chk("f_after_mread", 64'(m_read), 0);

    nxt; f_read = 1; d_read = 1; d_address = 64'h200; d_datasize = 3;
    #1 chk("s_owner0", 64'(owner), 0);
    nxt; #1;
    chk("s_owner2", 64'(owner), 2);
    chk("s_maddr", m_address, 64'h200);
    chk("s_mds", 64'(m_datasize), 3);
    m_done = 1; #1;
    chk("s_ddone", 64'(d_done), 1);
    chk("s_fdone", 64'(f_done), 0);
    nxt; m_done = 0; d_read = 0;
    #1;
    chk("s_bubble_owner", 64'(owner), 0);
    chk("s_bubble_mread", 64'(m_read), 0);
    nxt; #1;
    chk("s_owner1", 64'(owner), 1);
    chk("s_maddr_f", m_address, 64'h100);
    m_done = 1; #1 chk("s_fdone2", 64'(f_done), 1);
    nxt; m_done = 0; f_read = 0;

    nxt; f_read = 1; f_address = 64'h300; d_read = 1; d_address = 64'h310;
    for (int g = 0; g < 4; g++) begin
      nxt; #1 chk($sformatf("st_grant%0d", g), 64'(owner), 2);
      m_done = 1; #1 chk($sformatf("st_ddone%0d", g), 64'(d_done), 1);
      nxt; m_done = 0; #1 chk($sformatf("st_idle%0d", g), 64'(owner), 0);
    end
    nxt; #1;
    chk("st_fetch_owner", 64'(owner), 1);
    chk("st_fetch_addr", m_address, 64'h300);
    m_done = 1; #1 chk("st_fdone", 64'(f_done), 1);
    nxt; m_done = 0;
    nxt; #1 chk("st_cnt_cleared", 64'(owner), 2);
    m_done = 1;
    nxt; m_done = 0; d_read = 0; f_read = 0;

    nxt; d_read = 1; d_lock = 1; d_address = 64'h400; f_read = 1; f_address = 64'h410;
    nxt; #1;
    chk("cs_owner", 64'(owner), 2);
    chk("cs_mread", 64'(m_read), 1);
    m_done = 1; m_readdata = 64'h55; #1;
    chk("cs_ddone", 64'(d_done), 1);
    chk("cs_rdata", d_readdata, 64'h55);
    nxt; m_done = 0; d_read = 0; d_write = 1; d_lock = 0; d_writedata = 64'hABCD;
    #1;
    chk("cs_lock_owner", 64'(owner), 2);
    chk("cs_mwrite", 64'(m_write), 1);
    chk("cs_mread0", 64'(m_read), 0);
    chk("cs_wdata", m_writedata, 64'hABCD);
    nxt; m_done = 1; #1 chk("cs_wdone", 64'(d_done), 1);
    nxt; m_done = 0; d_write = 0;
    #1 chk("cs_bubble", 64'(owner), 0);
    nxt; #1;
    chk("cs_fetch", 64'(owner), 1);
    chk("cs_faddr", m_address, 64'h410);
    m_done = 1;
    nxt; m_done = 0; f_read = 0;

    nxt; d_read = 1; d_lock = 1;
    nxt; m_done = 1;
    nxt; m_done = 0; d_read = 0;
    #1 chk("lk_hold_owner", 64'(owner), 2);
    nxt; #1 chk("lk_hold_owner2", 64'(owner), 2);
    d_lock = 0;
    nxt; #1 chk("lk_release", 64'(owner), 0);

    nxt; d_write = 1; d_address = 64'h500; d_writedata = 64'h77;
    nxt; #1;
    chk("rw_mwrite", 64'(m_write), 1);
    d_read = 1; #1;
    chk("rw_prio_write", 64'(m_write), 0);
    chk("rw_prio_read", 64'(m_read), 1);
    d_read = 0; #1;
    reset = 1; #1;
    chk("rw_rst_mwrite", 64'(m_write), 0);
    chk("rw_rst_owner", 64'(owner), 0);
    m_done = 1; #1 chk("rw_rst_ddone", 64'(d_done), 0);
    nxt; reset = 0; m_done = 0; d_write = 0;
    nxt; m_done = 1; #1;
    chk("rw_late_ddone", 64'(d_done), 0);
    chk("rw_late_fdone", 64'(f_done), 0);
    nxt; m_done = 0; #1 chk("rw_late_owner", 64'(owner), 0);

    nxt; d_read = 1; d_address = 64'h600;
    nxt; #1 chk("ab_owner", 64'(owner), 2);
    d_read = 0; #1 chk("ab_mread", 64'(m_read), 0);
    nxt; #1 chk("ab_idle", 64'(owner), 0);
    m_done = 1; #1 chk("ab_stray", 64'(d_done), 0);
    nxt; m_done = 0; #1 chk("ab_stay_idle", 64'(owner), 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single core memory port between instruction fetch and the load/store unit. Sits between `fetch`/`exec_unit` and the memory controller. Forwards the held-level read/write request of the current owner, routes `mem_done`/`mem_readdata` back to that owner only, and keeps the data port owner-locked across the read-then-write pair of CSWAP.

## Interface
- `STARVE_LIMIT`, 4: consecutive data-port grants allowed while fetch waits before fetch is forced to win. Range 1..15.
- `clk` in 1: core clock.
- `reset` in 1: asynchronous, active-high reset.
- `f_address` in 64: fetch address; access size is always tetra.
- `f_read` in 1: fetch read request, held high until `f_done`.
- `f_readdata` out 64: memory read data, valid when `f_done`.
- `f_done` out 1: one-cycle completion pulse to fetch.
- `d_address` in 64: load/store address.
- `d_datasize` in 2: 0 byte, 1 wyde, 2 tetra, 3 octa.
- `d_read` in 1: data read request, held until `d_done`.
- `d_write` in 1: data write request, held until `d_done`.
- `d_writedata` in 64: store data.
- `d_lock` in 1: keep the grant after this transaction completes (CSWAP).
- `d_readdata` out 64: read data, valid when `d_done`.
- `d_done` out 1: one-cycle completion pulse to load/store.
- `m_address` out 64, `m_datasize` out 2, `m_read` out 1, `m_write` out 1, `m_writedata` out 64: memory-side request, levels held for the whole transaction.
- `m_readdata` in 64, `m_done` in 1: memory-side response; `m_done` is a one-cycle pulse.
- `owner` out 2: 0 none, 1 fetch, 2 data. For debug and perf counters.

## Operation
- States: IDLE, FETCH, DATA, LOCKED.
- IDLE: `owner` = none. All `m_*` outputs are 0. Requests are sampled and the winner is registered.
  - Data wins when `d_read|d_write` is high and the starve counter is below `STARVE_LIMIT`.
  - Otherwise fetch wins when `f_read` is high.
  - Data wins if only data requests.
- FETCH: `m_address=f_address`, `m_datasize=2`, `m_read=f_read`, `m_write=0`.
- DATA / LOCKED: `m_*` follow the `d_*` inputs combinationally. `m_read=d_read`, `m_write=d_write & ~d_read`, so read has priority if both are high.
- Done routing: `f_done=m_done & owner==fetch` and `d_done=m_done & owner==data`. Both readdata outputs carry `m_readdata` unconditionally.
- On `m_done` in FETCH: next state is IDLE.
- On `m_done` in DATA or LOCKED:
  - If `d_lock` is high, next state is LOCKED.
  - Otherwise, next state is IDLE.
- LOCKED: owner stays data and there is no arbitration.
  - The lock is released when a transaction completes with `d_lock` low.
  - The lock is also released when `d_lock`, `d_read` and `d_write` are all low, which returns to IDLE.
- Abort: if the owner's request levels drop before `m_done`, the arbiter returns to IDLE next cycle. The memory controller must tolerate a request withdrawn mid-access.
- Starve counter (4 bits):
  - Increments on each data grant from IDLE while `f_read` is high.
  - Clears on a fetch grant, or on any IDLE cycle with `f_read` low.
  - Saturates at `STARVE_LIMIT`.
- `m_done` arriving in IDLE is ignored and produces no done pulse.

## Timing
- Reset (async, immediate): state IDLE, `owner`=0, counter 0, so `m_read`=`m_write`=0, `m_address`=0, `m_datasize`=0, `m_writedata`=0, `f_done`=`d_done`=0.
- Reset asserted mid-transaction: `m_read`/`m_write` drop in the same cycle, and no done pulse is issued.
- Grant latency: request high in IDLE at cycle n, so `m_read`/`m_write` are high at cycle n+1.
- Done is combinational: `m_done` at cycle k gives `f_done` or `d_done` at cycle k.
- Turnaround: IDLE at k+1 with `m_*` low (one bubble cycle guaranteed between owners).
- LOCKED turnaround: no bubble. The next data request reaches `m_*` at k+1.
- Simultaneous requests in IDLE with counter below the limit: data wins.

## Structure
- `owner_t` enum (NONE, FETCH, DATA) and the datasize constants `DS_BYTE`/`DS_WYDE`/`DS_TETRA`/`DS_OCTA` go in the shared `mmix_defs` package.
- The state enum is local to the module.
- Single flat module. The request mux and the starve counter are too small to justify a sub-module.

## Test plan
- Fetch only: `f_read`=1, `f_address`=0x100; memory returns `m_done` at 3 cycles with data 0xDEAD -> `m_read` high from cycle 1, `m_datasize`=2, `f_done`=1 with `f_readdata`=0xDEAD, `d_done`=0, IDLE afterwards.
- Simultaneous request: `f_read`=`d_read`=1 -> data served first, one IDLE bubble, then fetch served. `owner` sequence 0,2,0,1.
- Starvation: `d_read` re-requested continuously, `f_read` held, `STARVE_LIMIT`=4 -> exactly 4 data grants, then a fetch grant, then the counter is 0.
- CSWAP lock: `d_read`+`d_lock`, done, then `d_write` with `d_lock`=0 while `f_read`=1 -> `m_write` at the cycle after the read done (no bubble), fetch granted only after the write done.
- Reset mid-write: `reset` pulsed during DATA with `m_write`=1 -> `m_write`=0 in the same cycle, `owner`=0, later `m_done` produces no `d_done`.
- Abort and stray done: `d_read` dropped before `m_done` -> IDLE next cycle, and a late `m_done` is ignored.
